// File: rtl/deser8.sv
// Serial-to-parallel deserializer: LSB-first bit stream in, WIDTH-bit word out.
// Optional even-parity frame check is compiled in with `define DESER_PARITY_EN.
module deser8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_next;
    logic             accept;
    logic             complete;

    // Handshake: a beat transfers on a rising edge where valid && ready; valid
    // never waits on ready, and a held output word stays stable until taken.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) in_ready = (state == COLLECT) || out_ready;
    end

    assign accept   = in_valid && in_ready;
    assign complete = accept && (state == COLLECT) && (cnt == LAST);

    // Shift register with the incoming bit placed at position cnt; a parity
    // beat (cnt == WIDTH) matches no position and leaves the data untouched.
    always_comb begin
        word_next = sr;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i)) word_next[i] = in;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (complete) state_next = FULL;
            FULL:    if (out_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= COLLECT;
            cnt       <= '0;
            sr        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FULL && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (state == FULL) begin
                    sr  <= {{(WIDTH-1){1'b0}}, in};
                    cnt <= CW'(1);
                end else if (complete) begin
                    out       <= word_next;
                    out_valid <= 1'b1;
                    sr        <= '0;
                    cnt       <= '0;
                end else begin
                    sr  <= word_next;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef DESER_PARITY_EN
    // Even parity: data bits XOR parity bit must be 0; word is delivered anyway.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_err <= 1'b0;
        end else if (complete) begin
            out_err <= (^sr) ^ in;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_deser8.sv
// Directed bench for deser8: handshake, stall, back-to-back, gaps, mid-word reset.
// Frames include an even-parity bit when DESER_PARITY_EN is defined.
module tb_deser8;

`ifdef DESER_PARITY_EN
    localparam int F = 9;
`else
    localparam int F = 8;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;

    int checks = 0;
    int passes = 0;
    int first_pulse;
    int second_pulse;
    int pulses;

    deser8 #(.WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Bit k of a frame: data LSB first, then the even-parity bit if enabled.
    function automatic logic frame_bit(input logic [7:0] w, input int k);
        if (k < 8) return w[k];
        return ^w;
    endfunction

    task automatic send_frame(input logic [7:0] w);
        in_valid = 1'b1;
        for (int k = 0; k < F; k++) begin
            in = frame_bit(w, k);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("rst_out", 16'(out), 16'h0);
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_err", 16'(out_err), 16'h0);
        check("rst_in_ready", 16'(in_ready), 16'h0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 16'(in_ready), 16'h1);

        // Word 0x4D streamed continuously; valid visible right after last beat.
        in_valid = 1'b1;
        for (int k = 0; k < F - 1; k++) begin
            in = frame_bit(8'h4D, k);
            cyc();
        end
        check("4d_early_valid", 16'(out_valid), 16'h0);
        in = frame_bit(8'h4D, F - 1);
        cyc();
        check("4d_valid", 16'(out_valid), 16'h1);
        check("4d_out", 16'(out), 16'h004D);
        check("4d_err", 16'(out_err), 16'h0);
        in_valid = 1'b0;
        cyc();
        check("4d_valid_drop", 16'(out_valid), 16'h0);
        check("4d_out_hold", 16'(out), 16'h004D);

        // Word 0xA5 held with consumer stalled while source keeps offering.
        out_ready = 1'b0;
        send_frame(8'hA5);
        check("a5_valid", 16'(out_valid), 16'h1);
        in_valid = 1'b1;
        in       = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stall_in_ready", 16'(in_ready), 16'h0);
            check("stall_out", 16'(out), 16'h00A5);
            check("stall_valid", 16'(out_valid), 16'h1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("take_in_ready", 16'(in_ready), 16'h1);
        cyc();
        check("take_valid_drop", 16'(out_valid), 16'h0);
        for (int k = 1; k < F; k++) begin
            in = frame_bit(8'h0B, k);
            cyc();
        end
        in_valid = 1'b0;
        check("0b_valid", 16'(out_valid), 16'h1);
        check("0b_out", 16'(out), 16'h000B);
        cyc();

        // Back-to-back 0xFF then 0x01 with no gap.
        first_pulse  = -1;
        second_pulse = -1;
        pulses       = 0;
        in_valid     = 1'b1;
        for (int k = 0; k < 2 * F; k++) begin
            in = (k < F) ? frame_bit(8'hFF, k) : frame_bit(8'h01, k - F);
            cyc();
            if (out_valid) begin
                pulses++;
                if (first_pulse < 0) begin
                    first_pulse = k;
                    check("b2b_first_out", 16'(out), 16'h00FF);
                end else begin
                    second_pulse = k;
                    check("b2b_second_out", 16'(out), 16'h0001);
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_pulses", 16'(pulses), 16'd2);
        check("b2b_spacing", 16'(second_pulse - first_pulse), 16'(F));

        // 0x3C with in_valid on alternate cycles; junk offered in gaps.
        for (int k = 0; k < 2 * F - 1; k++) begin
            if (k % 2 == 0) begin
                in_valid = 1'b1;
                in       = frame_bit(8'h3C, k / 2);
            end else begin
                in_valid = 1'b0;
                in       = 1'b1;
            end
            if (k == 2 * F - 2) check("gap_early_valid", 16'(out_valid), 16'h0);
            cyc();
        end
        in_valid = 1'b0;
        check("gap_valid", 16'(out_valid), 16'h1);
        check("gap_out", 16'(out), 16'h003C);
        cyc();

        // Reset after five bits of a word, then a fresh 0x81.
        in_valid = 1'b1;
        in       = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        in_valid = 1'b0;
        check("pre_rst_out", 16'(out), 16'h003C);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out", 16'(out), 16'h0);
        check("mid_rst_valid", 16'(out_valid), 16'h0);
        @(negedge clock);
        reset = 1'b0;
        send_frame(8'h81);
        check("81_valid", 16'(out_valid), 16'h1);
        check("81_out", 16'(out), 16'h0081);
        check("81_err", 16'(out_err), 16'h0);
        cyc();

`ifdef DESER_PARITY_EN
        // 0x07 with correct parity 1, then with wrong parity 0.
        send_frame(8'h07);
        check("par_ok_out", 16'(out), 16'h0007);
        check("par_ok_err", 16'(out_err), 16'h0);
        cyc();
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in = frame_bit(8'h07, k);
            cyc();
        end
        in = 1'b0;
        cyc();
        in_valid = 1'b0;
        check("par_bad_valid", 16'(out_valid), 16'h1);
        check("par_bad_out", 16'(out), 16'h0007);
        check("par_bad_err", 16'(out_err), 16'h1);
        cyc();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/deser8.md
Name: deser8

Overview:
- Bit-serial to parallel deserializer. It is the expansion counterpart of the 8-to-1 reduction gates: it assembles a serial bit stream into an 8-bit word.
- Sits between a 1-bit serial source (e.g. an input-device shifter) and the word-wide datapath/register file.
- Valid/ready handshake on both sides, with zero-bubble back-to-back word assembly.

Parameters:
- WIDTH, 8, number of serial bits per output word (supported range 2..16).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in  input  1  serial data bit, LSB of the word first
- in_valid  input  1  `in` carries a bit this cycle
- in_ready  output  1  block can accept a bit this cycle
- out  output  WIDTH  assembled word
- out_valid  output  1  `out` holds a complete word
- out_ready  input  1  consumer takes `out` this cycle
- out_err  output  1  parity error flag (DESER_PARITY_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, active-high), effective immediately:
  - out = 0, out_valid = 0, out_err = 0.
  - Bit counter cnt = 0, shift register = 0, state = COLLECT.
  - in_ready goes high in the first cycle after reset deasserts.
- Accept rule: a bit transfers on a rising edge where in_valid && in_ready. Bits offered while in_ready = 0 are ignored and not stored.
- Response to an abandoned bit: if in_valid drops without a transfer, nothing happens and no timeout applies.
- State COLLECT:
  - in_ready = 1.
  - Each accepted bit is written to shift-register position cnt, so the first bit received lands in out[0]. Then cnt increments.
  - On the accept that completes the word (cnt == WIDTH-1, or cnt == WIDTH with parity enabled):
    - out <= the assembled word in the same edge.
    - out_valid <= 1, cnt <= 0, state -> FULL.
  - Latency: out_valid rises on the edge of the last accepted bit, visible the following cycle. No extra pipeline stage.
- State FULL:
  - out and out_valid are held stable until out_ready = 1.
  - in_ready = out_ready (combinational pass-through). A new word's first bit can be accepted in the same cycle the current word is taken.
  - On out_valid && out_ready:
    - out_valid <= 0, unless that same edge also completes a new word. This is only possible when WIDTH bits arrive within a single cycle, which cannot happen, so out_valid always deasserts.
    - If in_valid is also high, the bit is accepted into position 0 and cnt <= 1.
    - state -> COLLECT.
  - If out_ready = 0: no state change, no bit accepted.
- Output stability: `out` changes only on word completion. It holds its last value after being taken, until the next word completes.
- cnt width: clog2(WIDTH+1). No wrap-around beyond WIDTH: the counter resets to 0 exactly on completion.
- Reset asserted mid-word: the partial word is discarded, with no output pulse.
- Reset asserted in FULL: the pending word is lost and out_valid drops immediately.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit (WIDTH+1 accepts per word).
  - out_err is registered alongside out: 1 when XOR of the data bits and the parity bit is 1.
  - out_err is held with out and cleared to 0 on reset.
  - The word is still delivered when out_err = 1.
- Undefined: frames are WIDTH bits, there is no parity stage, and out_err is constant 0.

Test Plan:
- Reset then stream 1,0,1,1,0,0,1,0 (LSB first) with in_valid held high and out_ready = 1 -> the cycle after the 8th accept shows out_valid = 1 and out = 8'h4D; out_valid drops the next cycle.
- Word 8'hA5 completed with out_ready = 0 for 5 cycles while in_valid stays high -> in_ready = 0 and out = 8'hA5 stable for all 5 cycles, no bits accepted; raising out_ready accepts the first bit of the next word in the same cycle.
- Two back-to-back words 8'hFF then 8'h01 with continuous in_valid and out_ready = 1 -> exactly 8 cycles between the two out_valid pulses, with no dropped bit.
- in_valid toggling every other cycle while streaming 8'h3C -> only valid cycles are counted; out = 8'h3C after 8 accepts (15 cycles).
- Assert reset after 5 bits of a word -> out_valid = 0 and out = 0 immediately; then a fresh 8'h81 stream yields out = 8'h81, proving the counter restarted at 0.
- With DESER_PARITY_EN: send 8'h07 then parity bit 1 -> out = 8'h07, out_err = 0. Send 8'h07 then parity bit 0 -> out = 8'h07, out_err = 1.
